// File: rtl/cr_sa_snap_reader_if.sv
// Command and readout handshake bundle between the SA snapshot reader and its
// CSR/debug requester.
interface cr_sa_snap_reader_if #(
  parameter int N_CNT = 16
);
  localparam int IW = $clog2(N_CNT);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] cmd_first;
  logic [IW-1:0] cmd_cnt;
  logic          cmd_clear;
  logic          cmd_err;

  logic          rd_valid;
  logic          rd_ready;
  logic [31:0]   rd_data;
  logic [IW-1:0] rd_idx;
  logic          rd_hi;
  logic          rd_last;

  modport master (
    output cmd_valid, cmd_first, cmd_cnt, cmd_clear, rd_ready,
    input  cmd_ready, cmd_err, rd_valid, rd_data, rd_idx, rd_hi, rd_last
  );

  modport slave (
    input  cmd_valid, cmd_first, cmd_cnt, cmd_clear, rd_ready,
    output cmd_ready, cmd_err, rd_valid, rd_data, rd_idx, rd_hi, rd_last
  );
endinterface

// File: rtl/cr_sa_snap_reader.sv
// SA counter bank readout: one coherent snap (optionally with clear) per command,
// then each selected 50-bit snapshot is streamed as a LO word and a HI word.
module cr_sa_snap_reader #(
  parameter int N_CNT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cr_sa_snap_reader_if.slave  bus,
  input  logic                abort,
  output logic                sa_snap,
  output logic                sa_clear,
  input  logic [49:0]         sa_snapshot [N_CNT],
  output logic                busy
);

  localparam int IW = $clog2(N_CNT);
  localparam logic [IW:0] MAX_IDX = (IW+1)'(N_CNT - 1);

  typedef enum logic [2:0] {IDLE, SNAP, LOAD, LO, HI} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, last_q;
  logic [49:0]   hold;
  logic          cmd_err_q;
  logic          accept, at_last, trunc;
  logic [IW:0]   range_end;
  logic [IW-1:0] last_calc;
  logic          cmd_ready, rd_valid, rd_hi, rd_last;
  logic [31:0]   rd_data;

  function automatic logic [31:0] word_sel(input logic [49:0] v, input logic hi);
    return hi ? {14'b0, v[49:32]} : v[31:0];
  endfunction

  // One extra bit so an oversized range is detected instead of wrapping.
  assign range_end = {1'b0, bus.cmd_first} + {1'b0, bus.cmd_cnt};
  assign trunc     = range_end > MAX_IDX;
  assign last_calc = trunc ? MAX_IDX[IW-1:0] : range_end[IW-1:0];
  assign accept    = (state == IDLE) && bus.cmd_valid;
  assign at_last   = (idx == last_q);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rd_valid  = 1'b0;
    rd_hi     = 1'b0;
    rd_last   = 1'b0;
    rd_data   = 32'd0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nxt = SNAP;
      end
      SNAP: state_nxt = LOAD;
      LOAD: state_nxt = LO;
      LO: begin
        rd_valid = 1'b1;
        rd_data  = word_sel(hold, 1'b0);
        if (bus.rd_ready) state_nxt = HI;
      end
      HI: begin
        rd_valid = 1'b1;
        rd_hi    = 1'b1;
        rd_last  = at_last;
        rd_data  = word_sel(hold, 1'b1);
        if (bus.rd_ready) state_nxt = at_last ? IDLE : LOAD;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  // Strobes come straight from the acceptance decision so they are clean flops
  // that are high only during SNAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      last_q    <= '0;
      hold      <= '0;
      sa_snap   <= 1'b0;
      sa_clear  <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      sa_snap   <= accept;
      sa_clear  <= accept && bus.cmd_clear;
      cmd_err_q <= accept && trunc;
      if (accept) begin
        idx    <= bus.cmd_first;
        last_q <= last_calc;
      end else if ((state == HI) && bus.rd_ready && !at_last) begin
        idx <= idx + 1'b1;
      end
      // Both halves of a word pair are served from this one capture.
      if (state == LOAD) hold <= sa_snapshot[idx];
    end
  end

  assign busy          = (state != IDLE);
  assign bus.cmd_ready = cmd_ready;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = rd_data;
  assign bus.rd_idx    = idx;
  assign bus.rd_hi     = rd_hi;
  assign bus.rd_last   = rd_last;

endmodule

// File: tb/tb_cr_sa_snap_reader.sv
// Directed bench for cr_sa_snap_reader with a small behavioural counter bank
// that captures on sa_snap and zeroes on sa_clear.
`define CHK(tag, o, e) chk(tag, 64'(o), 64'(e))

module tb_cr_sa_snap_reader;
  localparam int N_CNT = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        abort = 1'b0;
  logic        sa_snap, sa_clear, busy;
  logic        snap_q = 1'b0;
  logic [49:0] sa_snapshot [N_CNT];
  logic [49:0] cnt         [N_CNT];
  int          checks      = 0;
  int          errors      = 0;
  int          snap_pulses = 0;

  cr_sa_snap_reader_if #(.N_CNT(N_CNT)) bus ();

  cr_sa_snap_reader #(.N_CNT(N_CNT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .abort       (abort),
    .sa_snap     (sa_snap),
    .sa_clear    (sa_clear),
    .sa_snapshot (sa_snapshot),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ((sa_snap === 1'b1) && (snap_q === 1'b1)) begin
        errors++;
        $error("FAIL sa_snap high for two consecutive cycles");
      end
      checks++;
      if ((sa_clear === 1'b1) && (sa_snap !== 1'b1)) begin
        errors++;
        $error("FAIL sa_clear without sa_snap");
      end
      checks++;
      if ((bus.cmd_ready === 1'b1) == (busy === 1'b1)) begin
        errors++;
        $error("FAIL cmd_ready/busy inconsistent");
      end
    end
    snap_q <= (rst_n === 1'b1) ? sa_snap : 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the counter bank reacts to the strobes seen in that cycle.
  task automatic tick();
    logic s, c;
    s = sa_snap;
    c = sa_clear;
    @(posedge clk);
    #1;
    if (s) snap_pulses++;
    for (int i = 0; i < N_CNT; i++) begin
      if (s) sa_snapshot[i] = cnt[i];
      if (c) cnt[i] = '0;
    end
  endtask

  task automatic word(input string tag, input logic [31:0] d, input int idx,
                      input int hi, input int last);
    `CHK({tag, "_vld"},  bus.rd_valid, 1);
    `CHK({tag, "_data"}, bus.rd_data,  d);
    `CHK({tag, "_idx"},  bus.rd_idx,   idx);
    `CHK({tag, "_hi"},   bus.rd_hi,    hi);
    `CHK({tag, "_last"}, bus.rd_last,  last);
    tick();
  endtask

  task automatic issue(input int first, input int n, input logic clr);
    bus.cmd_first = first[3:0];
    bus.cmd_cnt   = n[3:0];
    bus.cmd_clear = clr;
    bus.cmd_valid = 1'b1;
    snap_pulses   = 0;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N_CNT; i++) begin
      cnt[i]         = '0;
      sa_snapshot[i] = '0;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_first = '0;
    bus.cmd_cnt   = '0;
    bus.cmd_clear = 1'b0;
    bus.rd_ready  = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    `CHK("rst_snap",  sa_snap,      0);
    `CHK("rst_clear", sa_clear,     0);
    `CHK("rst_vld",   bus.rd_valid, 0);
    `CHK("rst_data",  bus.rd_data,  0);
    `CHK("rst_hi",    bus.rd_hi,    0);
    `CHK("rst_last",  bus.rd_last,  0);
    `CHK("rst_err",   bus.cmd_err,  0);
    `CHK("rst_busy",  busy,         0);
    rst_n = 1'b1;
    tick();
    `CHK("rst_ready", bus.cmd_ready, 1);

    // Single counter, no clear
    cnt[3] = 50'h2_0000_0001_2345;
    bus.rd_ready = 1'b1;
    issue(3, 0, 1'b0);
    `CHK("t1_snap",  sa_snap,       1);
    `CHK("t1_clear", sa_clear,      0);
    `CHK("t1_err",   bus.cmd_err,   0);
    `CHK("t1_ready", bus.cmd_ready, 0);
    `CHK("t1_busy",  busy,          1);
    tick();
    `CHK("t1_load_vld",  bus.rd_valid, 0);
    `CHK("t1_load_snap", sa_snap,      0);
    tick();
    word("t1_lo", 32'h0001_2345, 3, 0, 0);
    word("t1_hi", 32'h0002_0000, 3, 1, 1);
    `CHK("t1_done_busy", busy,         0);
    `CHK("t1_done_vld",  bus.rd_valid, 0);
    `CHK("t1_pulses",    snap_pulses,  1);

    // Two counters with clear
    cnt[14] = 50'd100;
    cnt[15] = 50'd200;
    issue(14, 1, 1'b1);
    `CHK("t2_snap",  sa_snap,  1);
    `CHK("t2_clear", sa_clear, 1);
    tick();
    tick();
    word("t2_lo14", 32'd100, 14, 0, 0);
    word("t2_hi14", 32'd0,   14, 1, 0);
    `CHK("t2_bubble", bus.rd_valid, 0);
    tick();
    word("t2_lo15", 32'd200, 15, 0, 0);
    word("t2_hi15", 32'd0,   15, 1, 1);
    `CHK("t2_busy",   busy,        0);
    `CHK("t2_pulses", snap_pulses, 1);

    // Truncated range; counter 15 was cleared by the previous command
    issue(15, 3, 1'b0);
    `CHK("t3_err", bus.cmd_err, 1);
    tick();
    `CHK("t3_err_once", bus.cmd_err, 0);
    tick();
    word("t3_lo", 32'd0, 15, 0, 0);
    word("t3_hi", 32'd0, 15, 1, 1);
    `CHK("t3_busy", busy, 0);

    // Backpressure; source values change under a stalled word
    cnt[5] = 50'h3_FFFF_FFFF_FFFF;
    bus.rd_ready = 1'b0;
    issue(5, 0, 1'b0);
    tick();
    tick();
    sa_snapshot[5] = '0;
    cnt[5] = 50'd7;
    for (int k = 0; k < 5; k++) begin
      `CHK("t4_stall_vld",  bus.rd_valid, 1);
      `CHK("t4_stall_data", bus.rd_data,  32'hFFFF_FFFF);
      `CHK("t4_stall_idx",  bus.rd_idx,   5);
      `CHK("t4_stall_hi",   bus.rd_hi,    0);
      tick();
    end
    bus.rd_ready = 1'b1;
    word("t4_lo", 32'hFFFF_FFFF, 5, 0, 0);
    bus.rd_ready = 1'b0;
    tick();
    `CHK("t4_hi_stall_data", bus.rd_data, 32'h0003_FFFF);
    `CHK("t4_hi_stall_hi",   bus.rd_hi,   1);
    bus.rd_ready = 1'b1;
    word("t4_hi", 32'h0003_FFFF, 5, 1, 1);
    `CHK("t4_busy", busy, 0);

    // Abort during HI of counter 1 in a 4-counter read
    for (int i = 0; i < 4; i++) cnt[i] = 50'd10 + 50'(i);
    issue(0, 3, 1'b0);
    tick();
    tick();
    word("t5_lo0", 32'd10, 0, 0, 0);
    word("t5_hi0", 32'd0,  0, 1, 0);
    tick();
    word("t5_lo1", 32'd11, 1, 0, 0);
    `CHK("t5_in_hi", bus.rd_hi, 1);
    abort = 1'b1;
    tick();
    `CHK("t5_ab_vld",   bus.rd_valid,  0);
    `CHK("t5_ab_ready", bus.cmd_ready, 1);
    `CHK("t5_ab_busy",  busy,          0);
    `CHK("t5_ab_snap",  sa_snap,       0);
    tick();
    `CHK("t5_idle_ab_ready", bus.cmd_ready, 1);
    issue(2, 0, 1'b0);
    abort = 1'b0;
    `CHK("t5_new_snap", sa_snap, 1);
    tick();
    tick();
    word("t5_lo2", 32'd12, 2, 0, 0);
    word("t5_hi2", 32'd0,  2, 1, 1);
    `CHK("t5_pulses", snap_pulses, 1);

    // Asynchronous reset while in LOAD
    issue(1, 0, 1'b0);
    tick();
    `CHK("t6_busy_pre", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    `CHK("t6_snap",  sa_snap,      0);
    `CHK("t6_clear", sa_clear,     0);
    `CHK("t6_vld",   bus.rd_valid, 0);
    `CHK("t6_data",  bus.rd_data,  0);
    `CHK("t6_idx",   bus.rd_idx,   0);
    `CHK("t6_hi",    bus.rd_hi,    0);
    `CHK("t6_last",  bus.rd_last,  0);
    `CHK("t6_err",   bus.cmd_err,  0);
    `CHK("t6_busy",  busy,         0);
    tick();
    rst_n = 1'b1;
    tick();
    `CHK("t6_ready", bus.cmd_ready, 1);
    `CHK("t6_idle",  busy,          0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
